ram_arb2: RTL and testbench
===========================

RAM_ARB2 -- requirements
Module: ram_arb2

Interface — parameters
REQ-001 SHALL: DWIDTH, default 8, data width of the shared RAM and of every client data port.
REQ-002 SHALL: AWIDTH, default 10, address width of the shared RAM and of every client address port.

Interface — ports (N = 0,1, one port set per client)
REQ-003 SHALL: clk  in  1  single clock for all sequential logic.
REQ-004 SHALL: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL: cN_wreq  in  1  client N write request.
REQ-006 SHALL: cN_waddr  in  AWIDTH  client N write address.
REQ-007 SHALL: cN_wdata  in  DWIDTH  client N write data.
REQ-008 SHALL: cN_wgnt  out  1  client N write granted this cycle (combinational).
REQ-009 SHALL: cN_rreq  in  1  client N read request.
REQ-010 SHALL: cN_raddr  in  AWIDTH  client N read address.
REQ-011 SHALL: cN_rgnt  out  1  client N read granted this cycle (combinational).
REQ-012 SHALL: cN_rvalid  out  1  registered; cN_rdata is valid this cycle.
REQ-013 SHALL: cN_rdata  out  DWIDTH  read data, wired directly from ram_dout to both clients.
REQ-014 SHALL: ram_wen / ram_waddr / ram_din  out  1/AWIDTH/DWIDTH  RAM write port.
REQ-015 SHALL: ram_raddr  out  AWIDTH  RAM read address; the RAM registers it internally.
REQ-016 SHALL: ram_dout  in  DWIDTH  RAM read data, valid one cycle after ram_raddr is presented.

Function
REQ-017 SHALL: Write and read ports are arbitrated independently in the same cycle, each by its own 1-bit round-robin pointer (wptr, rptr).
REQ-018 SHALL: Grant rule per port: only one client requesting -> that client is granted; both requesting -> the client named by the pointer is granted; neither -> no grant.
REQ-019 SHALL: Pointer update at a clk edge with a grant to client k: pointer <= 1-k. Without a grant, the pointer holds.
REQ-020 SHALL: At most one of c0_wgnt/c1_wgnt and at most one of c0_rgnt/c1_rgnt is high in any cycle.
REQ-021 SHALL: A request not granted is not dropped; the client holds req/addr/data until it receives a grant.
REQ-022 SHALL: Write: ram_wen = c0_wgnt | c1_wgnt; ram_waddr/ram_din = granted client's waddr/wdata; both are 0 when there is no write grant.
REQ-023 SHALL: Read: ram_raddr = granted client's raddr; 0 when there is no read grant.
REQ-024 SHALL: Read latency: a read granted in cycle T asserts cN_rvalid for exactly one cycle at T+1, and only for the granted client.
REQ-025 SHALL: Back-to-back reads are fully pipelined: one read grant per cycle, one rvalid per cycle.
REQ-026 SHALL: Same-cycle write and read to the same address return the newly written data at T+1, because the RAM writes before the registered-address read.
REQ-027 SHALL: Outstanding reads per port are at most 1 in flight; no FIFO is needed and the return tag is a 2-bit one-hot register.
REQ-028 SHALL: Fairness: with both clients requesting continuously, grants strictly alternate, so each client waits at most 1 cycle.

Reset
REQ-029 SHALL: Asserting rst asynchronously clears wptr and rptr to 0 (client 0 preferred), clears both cN_rvalid, and forces all grants and ram_wen to 0 while rst is high.
REQ-030 SHALL: A read granted in the cycle reset is asserted produces no rvalid; after rst deasserts, the first edge arbitrates normally.

Verification
REQ-031 SHALL: Reset, then c0_wreq=c1_wreq=1 (addr 5/6, data 8'hA5/8'h5A) for 2 cycles -> cycle 1 c0_wgnt, ram_waddr=5; cycle 2 c1_wgnt, ram_waddr=6.
REQ-032 SHALL: Only c1_rreq=1, raddr=6 -> c1_rgnt same cycle, c1_rvalid=1 with c1_rdata=8'h5A next cycle, c0_rvalid stays 0.
REQ-033 SHALL: Both clients read continuously for 6 cycles -> rgnt alternates 0,1,0,1,0,1 and rvalid alternates one cycle later, with no gaps.
REQ-034 SHALL: Same cycle c0 writes addr 9 data 8'h3C and c1 reads addr 9 -> both granted, and c1_rdata=8'h3C at T+1.
REQ-035 SHALL: rst pulsed mid-stream (during a read grant) -> rvalid=0 immediately, and the next arbitration after release prefers client 0.
REQ-036 SHALL: Random traffic against a reference memory model -> every rvalid returns model data and no grant is ever one-hot-violated.

Source files
------------

// File: rtl/ram_arb2_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb2_if
// Brief    : Two-client / one-RAM bus bundle for the ram_arb2 arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_arb2_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 10
);
  logic              c0_wreq,   c1_wreq;
  logic [AWIDTH-1:0] c0_waddr,  c1_waddr;
  logic [DWIDTH-1:0] c0_wdata,  c1_wdata;
  logic              c0_wgnt,   c1_wgnt;
  logic              c0_rreq,   c1_rreq;
  logic [AWIDTH-1:0] c0_raddr,  c1_raddr;
  logic              c0_rgnt,   c1_rgnt;
  logic              c0_rvalid, c1_rvalid;
  logic [DWIDTH-1:0] c0_rdata,  c1_rdata;
  logic              ram_wen;
  logic [AWIDTH-1:0] ram_waddr;
  logic [DWIDTH-1:0] ram_din;
  logic [AWIDTH-1:0] ram_raddr;
  logic [DWIDTH-1:0] ram_dout;

  // Arbiter side
  modport slave (
    input  c0_wreq, c1_wreq, c0_waddr, c1_waddr, c0_wdata, c1_wdata,
    input  c0_rreq, c1_rreq, c0_raddr, c1_raddr, ram_dout,
    output c0_wgnt, c1_wgnt, c0_rgnt, c1_rgnt, c0_rvalid, c1_rvalid,
    output c0_rdata, c1_rdata, ram_wen, ram_waddr, ram_din, ram_raddr
  );

  // Clients plus RAM side
  modport master (
    output c0_wreq, c1_wreq, c0_waddr, c1_waddr, c0_wdata, c1_wdata,
    output c0_rreq, c1_rreq, c0_raddr, c1_raddr, ram_dout,
    input  c0_wgnt, c1_wgnt, c0_rgnt, c1_rgnt, c0_rvalid, c1_rvalid,
    input  c0_rdata, c1_rdata, ram_wen, ram_waddr, ram_din, ram_raddr
  );
endinterface
`default_nettype wire

// File: rtl/ram_arb2.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb2
// Brief    : Round-robin arbiter sharing one 1W/1R RAM between two clients.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arb2 #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 10
) (
  input  logic       clk,
  input  logic       rst,
  ram_arb2_if.slave  bus
);
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_rtag;

  logic              w_wgnt0, w_wgnt1, w_rgnt0, w_rgnt1;
  logic [AWIDTH-1:0] w_waddr, w_raddr;
  logic [DWIDTH-1:0] w_wdata;

  // Pointer names the preferred client only when both request; rst masks grants
  assign w_wgnt0 = !rst && bus.c0_wreq && (!bus.c1_wreq || !r_wptr);
  assign w_wgnt1 = !rst && bus.c1_wreq && (!bus.c0_wreq ||  r_wptr);
  assign w_rgnt0 = !rst && bus.c0_rreq && (!bus.c1_rreq || !r_rptr);
  assign w_rgnt1 = !rst && bus.c1_rreq && (!bus.c0_rreq ||  r_rptr);

  assign w_waddr = w_wgnt0 ? bus.c0_waddr : (w_wgnt1 ? bus.c1_waddr : '0);
  assign w_wdata = w_wgnt0 ? bus.c0_wdata : (w_wgnt1 ? bus.c1_wdata : '0);
  assign w_raddr = w_rgnt0 ? bus.c0_raddr : (w_rgnt1 ? bus.c1_raddr : '0);

  assign bus.c0_wgnt   = w_wgnt0;
  assign bus.c1_wgnt   = w_wgnt1;
  assign bus.c0_rgnt   = w_rgnt0;
  assign bus.c1_rgnt   = w_rgnt1;
  assign bus.ram_wen   = w_wgnt0 | w_wgnt1;
  assign bus.ram_waddr = w_waddr;
  assign bus.ram_din   = w_wdata;
  assign bus.ram_raddr = w_raddr;

  // RAM registers the address, so the one-hot tag lines up with ram_dout
  assign bus.c0_rvalid = r_rtag[0];
  assign bus.c1_rvalid = r_rtag[1];
  assign bus.c0_rdata  = bus.ram_dout;
  assign bus.c1_rdata  = bus.ram_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_rtag <= 2'b00;
    end else begin
      if (w_wgnt0)      r_wptr <= 1'b1;
      else if (w_wgnt1) r_wptr <= 1'b0;
      if (w_rgnt0)      r_rptr <= 1'b1;
      else if (w_rgnt1) r_rptr <= 1'b0;
      r_rtag <= {w_rgnt1, w_rgnt0};
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ram_arb2.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arb2
// Brief    : Directed and random self-checking bench for ram_arb2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arb2;
  localparam int C_DW = 8;
  localparam int C_AW = 10;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ram_arb2_if #(.DWIDTH(C_DW), .AWIDTH(C_AW)) bus ();

  ram_arb2 #(.DWIDTH(C_DW), .AWIDTH(C_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: write lands before the registered-address read
  logic [C_DW-1:0] mem [0:(1<<C_AW)-1];
  logic [C_DW-1:0] r_dout;
  initial begin
    for (int i = 0; i < (1 << C_AW); i++) mem[i] = '0;
    r_dout = '0;
  end
  always @(posedge clk) begin
    if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_din;
    r_dout <= (bus.ram_wen && bus.ram_waddr == bus.ram_raddr) ? bus.ram_din
                                                              : mem[bus.ram_raddr];
  end
  assign bus.ram_dout = r_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.c0_wreq = 0; bus.c1_wreq = 0; bus.c0_rreq = 0; bus.c1_rreq = 0;
    bus.c0_waddr = '0; bus.c1_waddr = '0; bus.c0_wdata = '0; bus.c1_wdata = '0;
    bus.c0_raddr = '0; bus.c1_raddr = '0;
  endtask

  // Reference state for the random phase
  logic [C_DW-1:0] ref_mem [0:31];
  logic            mw, mr, pw0, pw1, pr0, pr1;
  logic            ewg0, ewg1, erg0, erg1;
  logic [C_AW-1:0] wa0, wa1, ra0, ra1, wa_e, ra_e;
  logic [C_DW-1:0] wd0, wd1, wd_e, exp_rd;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    idle();
    bus.c0_wreq = 1; bus.c1_rreq = 1;
    #2;
    check("rst_wgnt",   {bus.c1_wgnt, bus.c0_wgnt}, 0);
    check("rst_rgnt",   {bus.c1_rgnt, bus.c0_rgnt}, 0);
    check("rst_wen",    bus.ram_wen, 0);
    check("rst_rvalid", {bus.c1_rvalid, bus.c0_rvalid}, 0);
    idle();
    tick(); tick();
    rst = 1'b0;

    // Both clients write: client 0 first, then client 1
    bus.c0_wreq = 1; bus.c0_waddr = 5; bus.c0_wdata = 8'hA5;
    bus.c1_wreq = 1; bus.c1_waddr = 6; bus.c1_wdata = 8'h5A;
    #1;
    check("w1_gnt",   {bus.c1_wgnt, bus.c0_wgnt}, 2'b01);
    check("w1_waddr", bus.ram_waddr, 5);
    check("w1_din",   bus.ram_din, 8'hA5);
    tick();
    check("w2_gnt",   {bus.c1_wgnt, bus.c0_wgnt}, 2'b10);
    check("w2_waddr", bus.ram_waddr, 6);
    check("w2_din",   bus.ram_din, 8'h5A);
    tick();
    idle();
    #1;
    check("idle_wen",   bus.ram_wen, 0);
    check("idle_waddr", bus.ram_waddr, 0);
    check("idle_din",   bus.ram_din, 0);
    check("idle_raddr", bus.ram_raddr, 0);

    // Single reader on client 1
    bus.c1_rreq = 1; bus.c1_raddr = 6;
    #1;
    check("r1_gnt",   {bus.c1_rgnt, bus.c0_rgnt}, 2'b10);
    check("r1_raddr", bus.ram_raddr, 6);
    tick();
    idle();
    check("r1_rvalid", {bus.c1_rvalid, bus.c0_rvalid}, 2'b10);
    check("r1_rdata",  bus.c1_rdata, 8'h5A);

    // Continuous reads from both: strict alternation, no gaps
    bus.c0_rreq = 1; bus.c0_raddr = 5;
    bus.c1_rreq = 1; bus.c1_raddr = 6;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("alt_gnt", {bus.c1_rgnt, bus.c0_rgnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check("alt_rvalid", {bus.c1_rvalid, bus.c0_rvalid}, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("alt_rdata",  bus.c0_rdata, (i % 2 == 0) ? 8'hA5 : 8'h5A);
    end
    idle();

    // Same-cycle write and read of one address
    bus.c0_wreq = 1; bus.c0_waddr = 9; bus.c0_wdata = 8'h3C;
    bus.c1_rreq = 1; bus.c1_raddr = 9;
    #1;
    check("wr_wgnt", {bus.c1_wgnt, bus.c0_wgnt}, 2'b01);
    check("wr_rgnt", {bus.c1_rgnt, bus.c0_rgnt}, 2'b10);
    tick();
    idle();
    check("wr_rvalid", {bus.c1_rvalid, bus.c0_rvalid}, 2'b10);
    check("wr_rdata",  bus.c1_rdata, 8'h3C);

    // Mid-stream reset with pointers left pointing at client 1
    bus.c0_rreq = 1; bus.c0_raddr = 5;
    tick();
    check("mr_pre_rvalid", bus.c0_rvalid, 1);
    bus.c1_rreq = 1; bus.c1_raddr = 6;
    #1;
    check("mr_pre_gnt", {bus.c1_rgnt, bus.c0_rgnt}, 2'b10);
    rst = 1'b1;
    #1;
    check("mr_rvalid_now", {bus.c1_rvalid, bus.c0_rvalid}, 0);
    check("mr_gnt_now",    {bus.c1_rgnt, bus.c0_rgnt}, 0);
    tick();
    check("mr_rvalid_after", {bus.c1_rvalid, bus.c0_rvalid}, 0);
    bus.c0_wreq = 1; bus.c0_waddr = 40; bus.c0_wdata = 8'h11;
    bus.c1_wreq = 1; bus.c1_waddr = 41; bus.c1_wdata = 8'h22;
    rst = 1'b0;
    #1;
    check("mr_rel_rgnt", {bus.c1_rgnt, bus.c0_rgnt}, 2'b01);
    check("mr_rel_wgnt", {bus.c1_wgnt, bus.c0_wgnt}, 2'b01);
    tick();
    idle();
    check("mr_rel_rvalid", {bus.c1_rvalid, bus.c0_rvalid}, 2'b01);
    check("mr_rel_rdata",  bus.c0_rdata, 8'hA5);

    // Random traffic in addresses 16..31 against a reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    mw = 0; mr = 0; pw0 = 0; pw1 = 0; pr0 = 0; pr1 = 0;
    wa0 = '0; wa1 = '0; ra0 = '0; ra1 = '0; wd0 = '0; wd1 = '0;
    for (int n = 0; n < 200; n++) begin
      if (!pw0 && $urandom_range(0, 1) == 1) begin
        pw0 = 1; wa0 = C_AW'(16 + $urandom_range(0, 15)); wd0 = C_DW'($urandom_range(0, 255));
      end
      if (!pw1 && $urandom_range(0, 1) == 1) begin
        pw1 = 1; wa1 = C_AW'(16 + $urandom_range(0, 15)); wd1 = C_DW'($urandom_range(0, 255));
      end
      if (!pr0 && $urandom_range(0, 1) == 1) begin
        pr0 = 1; ra0 = C_AW'(16 + $urandom_range(0, 15));
      end
      if (!pr1 && $urandom_range(0, 1) == 1) begin
        pr1 = 1; ra1 = C_AW'(16 + $urandom_range(0, 15));
      end
      bus.c0_wreq = pw0; bus.c0_waddr = wa0; bus.c0_wdata = wd0;
      bus.c1_wreq = pw1; bus.c1_waddr = wa1; bus.c1_wdata = wd1;
      bus.c0_rreq = pr0; bus.c0_raddr = ra0;
      bus.c1_rreq = pr1; bus.c1_raddr = ra1;
      #1;
      ewg0 = pw0 && (!pw1 || !mw);
      ewg1 = pw1 && (!pw0 ||  mw);
      erg0 = pr0 && (!pr1 || !mr);
      erg1 = pr1 && (!pr0 ||  mr);
      check("rnd_wgnt", {bus.c1_wgnt, bus.c0_wgnt}, {ewg1, ewg0});
      check("rnd_rgnt", {bus.c1_rgnt, bus.c0_rgnt}, {erg1, erg0});
      check("rnd_onehot", ($countones({bus.c1_wgnt, bus.c0_wgnt}) <= 1) &&
                          ($countones({bus.c1_rgnt, bus.c0_rgnt}) <= 1), 1);
      wa_e = ewg0 ? wa0 : wa1;
      wd_e = ewg0 ? wd0 : wd1;
      ra_e = erg0 ? ra0 : ra1;
      exp_rd = ((ewg0 || ewg1) && wa_e == ra_e) ? wd_e : ref_mem[ra_e[4:0]];
      if (ewg0 || ewg1) ref_mem[wa_e[4:0]] = wd_e;
      if (ewg0) begin mw = 1; pw0 = 0; end
      else if (ewg1) begin mw = 0; pw1 = 0; end
      if (erg0) begin mr = 1; pr0 = 0; end
      else if (erg1) begin mr = 0; pr1 = 0; end
      tick();
      check("rnd_rvalid", {bus.c1_rvalid, bus.c0_rvalid}, {erg1, erg0});
      if (erg0 || erg1) check("rnd_rdata", bus.c0_rdata, exp_rd);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
